// File: rtl/sd_clkdiv_pkg.sv
// Shared types and constants for the SD card clock divider.
// Divisor constants are half-period reload values: f_out = f_in / (2*(div+1)).
package sd_clkdiv_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    // 27 MHz / 68 gives ~397 kHz, inside the SD identification window.
    localparam int SD_DIV_INIT = 33;
    localparam int SD_DIV_FAST = 0;

endpackage

// File: rtl/sd_clkdiv_ch.sv
// One divided-clock channel: half-period counter, glitch-free stop, deferred divisor apply, lock tracking.
// Latency: clk_o/rise_o/fall_o registered, first rise cur_div+1 cycles after enable; no backpressure.
module sd_clkdiv_ch
    import sd_clkdiv_pkg::*;
#(
    parameter int DIV_W        = 8,
    parameter int RST_DIV      = SD_DIV_INIT,
    parameter int LOCK_PERIODS = 4
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_ld_i,
    input  logic             en_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             pend_o,
    output logic             lock_o
);
    localparam int               LW        = $clog2(LOCK_PERIODS + 1);
    localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);
    localparam logic [LW-1:0]    LOCK_MAX  = LW'(LOCK_PERIODS);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [LW-1:0]    lock_q, lock_d;
    logic             hit;
    logic [DIV_W-1:0] cnt_step;
    logic             apply_win;
    logic             apply;

    assign hit      = (cnt_q == cur_div_q);
    assign cnt_step = hit ? '0 : cnt_q + DIV_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            CH_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en_i) state_d = CH_RUN;
            end
            CH_RUN, CH_DRAIN: begin
                if (state_q == CH_RUN && !en_i && !clk_q) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_step;
                    if (hit) begin
                        clk_d  = ~clk_q;
                        rise_d = ~clk_q;
                        fall_d = clk_q;
                    end
                    // Disabled here implies clk_q=1, so a hit is the closing fall.
                    if (en_i)     state_d = CH_RUN;
                    else if (hit) state_d = CH_IDLE;
                    else          state_d = CH_DRAIN;
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    // Divisor changes only land on a falling edge or while idle, so no phase is ever shortened.
    assign apply_win = fall_d || (state_q == CH_IDLE);
    assign apply     = apply_win && (div_ld_i || pend_q);

    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        if (div_ld_i) begin
            pend_div_d = div_i;
            if (apply_win) begin
                cur_div_d = div_i;
                pend_d    = 1'b0;
            end else begin
                pend_d    = 1'b1;
            end
        end else if (apply) begin
            cur_div_d = pend_div_q;
            pend_d    = 1'b0;
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (apply || state_d == CH_IDLE) begin
            lock_d = '0;
        end else if (rise_d && lock_q != LOCK_MAX) begin
            lock_d = lock_q + LW'(1);
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CH_IDLE;
            cnt_q      <= '0;
            cur_div_q  <= RST_DIV_V;
            pend_div_q <= RST_DIV_V;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            lock_q     <= lock_d;
        end
    end

    assign clk_o  = clk_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign pend_o = pend_q;
    assign lock_o = (lock_q == LOCK_MAX);

endmodule

// File: rtl/sd_clkdiv.sv
// Multi-channel SD clock divider: N_CH independent sd_clkdiv_ch instances sliced from flat buses.
// Latency: as per channel (registered outputs); no backpressure.
module sd_clkdiv
    import sd_clkdiv_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int DIV_W        = 8,
    parameter int RST_DIV      = SD_DIV_INIT,
    parameter int LOCK_PERIODS = 4
) (
    input  logic                  clkin,
    input  logic                  reset_n,
    input  logic [N_CH*DIV_W-1:0] div_i,
    input  logic [N_CH-1:0]       div_ld_i,
    input  logic [N_CH-1:0]       en_i,
    output logic [N_CH-1:0]       clk_o,
    output logic [N_CH-1:0]       rise_o,
    output logic [N_CH-1:0]       fall_o,
    output logic [N_CH-1:0]       pend_o,
    output logic [N_CH-1:0]       lock_o
);
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        sd_clkdiv_ch #(
            .DIV_W        (DIV_W),
            .RST_DIV      (RST_DIV),
            .LOCK_PERIODS (LOCK_PERIODS)
        ) u_ch (
            .clkin    (clkin),
            .reset_n  (reset_n),
            .div_i    (div_i[k*DIV_W +: DIV_W]),
            .div_ld_i (div_ld_i[k]),
            .en_i     (en_i[k]),
            .clk_o    (clk_o[k]),
            .rise_o   (rise_o[k]),
            .fall_o   (fall_o[k]),
            .pend_o   (pend_o[k]),
            .lock_o   (lock_o[k])
        );
    end

endmodule

// File: doc/sd_clkdiv.md
SD_CLKDIV -- requirements
Module: sd_clkdiv

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent clock channels.
REQ-002 SHALL have parameter DIV_W, default 8: divisor width.
REQ-003 SHALL have parameter RST_DIV, default 33: divisor after reset (27 MHz / 68 ≈ 397 kHz, SD identification rate).
REQ-004 SHALL have parameter LOCK_PERIODS, default 4: stable rising edges required before lock_o asserts.
REQ-005 SHALL have port clkin, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port div_i, input, N_CH*DIV_W: per-channel requested divisor, channel k at bits [k*DIV_W +: DIV_W].
REQ-008 SHALL have port div_ld_i, input, N_CH: per-channel one-cycle strobe capturing div_i.
REQ-009 SHALL have port en_i, input, N_CH: per-channel run enable.
REQ-010 SHALL have port clk_o, output, N_CH: registered divided clock.
REQ-011 SHALL have port rise_o, output, N_CH: one-cycle pulse in the cycle clk_o becomes 1.
REQ-012 SHALL have port fall_o, output, N_CH: one-cycle pulse in the cycle clk_o becomes 0.
REQ-013 SHALL have port pend_o, output, N_CH: divisor change captured, not yet applied.
REQ-014 SHALL have port lock_o, output, N_CH: channel running stably at its current divisor.

Function
REQ-015 Each channel SHALL hold a half-period counter cnt (DIV_W bits) and an active divisor cur_div; channels SHALL be fully independent.
REQ-016 While running, cnt SHALL increment each cycle; when cnt == cur_div, cnt SHALL return to 0 and clk_o SHALL toggle, giving period 2*(cur_div+1) clkin cycles and 50 % duty.
REQ-017 cur_div = 0 SHALL be legal and yield clkin/2; cur_div = 2^DIV_W-1 SHALL be legal, with no counter wrap beyond cur_div.
REQ-018 rise_o/fall_o SHALL be registered with clk_o and assert in exactly the cycle clk_o changes; never both at once.
REQ-019 Channel states: IDLE (clk_o=0, cnt held 0), RUN, DRAIN (en_i=0 while clk_o=1).
REQ-020 IDLE->RUN when en_i=1; first rising edge cur_div+1 cycles after the en_i=1 cycle.
REQ-021 RUN->DRAIN when en_i=0 with clk_o=1: high phase completes normally, then IDLE; RUN->IDLE directly when en_i=0 with clk_o=0 (cnt cleared); no runt pulses ever.
REQ-022 DRAIN->RUN when en_i returns to 1 before the fall: continue counting without disturbance.
REQ-023 div_ld_i SHALL capture div_i into pend_div and set pend_o; a further load while pending SHALL overwrite pend_div (last wins).
REQ-024 The pending divisor SHALL be applied (cur_div <= pend_div, pend_o <= 0) in the cycle of a fall_o, or in the first cycle the channel is IDLE.
REQ-025 If div_ld_i coincides with an apply cycle, div_i SHALL be applied directly and pend_o SHALL end at 0.
REQ-026 A lock counter SHALL count rise_o pulses, saturating at LOCK_PERIODS; lock_o = 1 when saturated.
REQ-027 Apply of a divisor or entry to IDLE SHALL clear the lock counter and lock_o in the same cycle.

Reset
REQ-028 On reset_n=0 asynchronously: clk_o, rise_o, fall_o, pend_o, lock_o = 0; cnt = 0; cur_div = RST_DIV; pend_div = RST_DIV; state IDLE.
REQ-029 Release SHALL be synchronous to clkin; inputs sampled from the first edge after release.
REQ-030 Reset mid-period SHALL drop clk_o immediately; no pending load survives reset.

Structure
REQ-031 Package sd_clkdiv_pkg SHALL hold the channel state enum, SD_DIV_INIT (33) and SD_DIV_FAST (0) constants.
REQ-032 Per-channel logic SHALL be sub-module sd_clkdiv_ch, instantiated N_CH times by a generate loop; the top contains only slicing.

Verification
REQ-033 Reset, en_i[0]=1, div=RST_DIV: first rise_o at cycle 34, clk_o period 68, lock_o at 4th rise (cycle 34+3*68 = 238).
REQ-034 div_ld_i with div_i=0 mid high phase: pend_o=1 until the next fall_o, then period 2 with lock_o cleared and relocking after 4 rises.
REQ-035 en_i=0 one cycle after a rise at div 3: clk_o stays high 4 cycles total, then 0; cnt 0; lock_o 0.
REQ-036 Two loads (5, then 9) before a fall: only 9 applied; period 20; load coinciding with fall applies directly.
REQ-037 Channel 0 div 1 and channel 1 div 255 simultaneously: periods 4 and 512, independent; ch1 load does not perturb ch0.
REQ-038 reset_n pulsed low mid-high phase: all outputs 0 asynchronously; after release cur_div = 33.
